// File: rtl/lsu_mem_if_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states, size-to-mask helper.
// Latency: n/a (types, constants and one pure function only).
// Backpressure: n/a.
package lsu_pkg;

    // RV32I load/store width codes. Stores only use the first three.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } state_t;

    // Byte-lane mask for an access of the given size (funct3[1:0]), lane 0 aligned.
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_if_if.sv
// Request/response bus between the execute stage (master) and the load/store unit (slave).
// Latency: n/a (wires only).
// Backpressure: req_valid/req_ready handshake; responses are single-cycle pulses with no ready.
// Ports: req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata toward the unit,
//        resp_valid/resp_rdata/resp_misaligned back to the execute stage.
interface lsu_bus_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_misaligned
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_misaligned
    );
endinterface

// File: rtl/lsu_mem_if_align.sv
// Combinational 64-bit lane shifter: places store mask/data at byte offset, extracts and extends load data.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; outputs follow inputs.
// Ports: funct3_i/off_i select size and offset; wdata_i store data; rd_lo_i/rd_hi_i low/high read words;
//        mask8_o/wdata64_o span two words (upper half = spill into next word); rdata_o extended load data.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rd_lo_i,
    input  logic [31:0] rd_hi_i,
    output logic [7:0]  mask8_o,
    output logic [63:0] wdata64_o,
    output logic [31:0] rdata_o
);

    logic [63:0] rd64;

    assign mask8_o   = {4'b0000, size_mask(funct3_i[1:0])} << off_i;
    assign wdata64_o = {32'h0, wdata_i} << {off_i, 3'b000};
    assign rd64      = {rd_hi_i, rd_lo_i} >> {off_i, 3'b000};

    always_comb begin
        rdata_o = 32'h0;
        case (funct3_i)
            F3_B:    rdata_o = {{24{rd64[7]}}, rd64[7:0]};
            F3_H:    rdata_o = {{16{rd64[15]}}, rd64[15:0]};
            F3_W:    rdata_o = rd64[31:0];
            F3_BU:   rdata_o = {24'h0, rd64[7:0]};
            F3_HU:   rdata_o = {16'h0, rd64[15:0]};
            default: rdata_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_if.sv
// Load/store unit in front of a word-addressed, byte-masked data memory; splits misaligned accesses in two beats.
// Latency: 1 cycle aligned/illegal/trapped, 2 cycles split; back-to-back accepts allowed while in IDLE.
// Backpressure: req_ready low only during the second beat of a split access.
// Ports: clk/rst (async active-high); bus (lsu_bus_if.slave) request/response; mem_en/mem_mask/mem_data_in/
//        mem_address drive the memory, mem_data_out is its combinational read data.
// Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned requests instead of splitting them.
module lsu_mem_if
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    lsu_bus_if.slave          bus,
    output logic              mem_en,
    output logic [3:0]        mem_mask,
    output logic [XLEN-1:0]   mem_data_in,
    output logic [ADDR_W-1:0] mem_address,
    input  logic [XLEN-1:0]   mem_data_out
);

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_t            state_q;
    logic              resp_valid_q;
    logic [31:0]       resp_rdata_q;
    logic [31:0]       hold_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;

    logic [1:0]  off;
    logic        accept;
    logic        is_legal;
    logic        is_mis;
    logic        wr_first;
    logic [2:0]  al_f3;
    logic [1:0]  al_off;
    logic [31:0] al_wdata;
    logic [31:0] al_lo;
    logic [31:0] al_hi;
    logic [7:0]  mask8;
    logic [63:0] wdata64;
    logic [31:0] ld_data;

    // Bits above the 16 KiB window are dropped so addresses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.req_addr[31:ADDR_W+2];

    assign off    = bus.req_addr[1:0];
    assign accept = bus.req_valid && (state_q == IDLE);

    always_comb begin
        is_legal = 1'b0;
        case (bus.req_funct3)
            F3_B, F3_H, F3_W: is_legal = 1'b1;
            F3_BU, F3_HU:     is_legal = !bus.req_we;
            default:          is_legal = 1'b0;
        endcase
    end

    // Halfword at offset 1 still fits in one word, so only offset 3 spills.
    assign is_mis = is_legal &&
                    (((bus.req_funct3[1:0] == 2'b01) && (off == 2'b11)) ||
                     ((bus.req_funct3[1:0] == 2'b10) && (off != 2'b00)));

    assign wr_first = accept && bus.req_we && is_legal && !(is_mis && TRAP_EN);

    // In SECOND the shifter works on the latched request; the low word comes from the hold register.
    always_comb begin
        if (state_q == SECOND) begin
            al_f3    = f3_q;
            al_off   = off_q;
            al_wdata = wdata_q;
            al_lo    = hold_q;
            al_hi    = mem_data_out;
        end else begin
            al_f3    = bus.req_funct3;
            al_off   = off;
            al_wdata = bus.req_wdata;
            al_lo    = mem_data_out;
            al_hi    = 32'h0;
        end
    end

    lsu_align u_align (
        .funct3_i  (al_f3),
        .off_i     (al_off),
        .wdata_i   (al_wdata),
        .rd_lo_i   (al_lo),
        .rd_hi_i   (al_hi),
        .mask8_o   (mask8),
        .wdata64_o (wdata64),
        .rdata_o   (ld_data)
    );

    always_comb begin
        mem_en      = 1'b0;
        mem_mask    = 4'h0;
        mem_data_in = '0;
        mem_address = bus.req_addr[ADDR_W+1:2];
        if (state_q == SECOND) begin
            mem_address = addr_q + ADDR_W'(1);
        end
        if (!rst) begin
            if (state_q == SECOND) begin
                if (we_q) begin
                    mem_en      = 1'b1;
                    mem_mask    = mask8[7:4];
                    mem_data_in = wdata64[63:32];
                end
            end else if (wr_first) begin
                mem_en      = 1'b1;
                mem_mask    = mask8[3:0];
                mem_data_in = wdata64[31:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            hold_q       <= 32'h0;
            f3_q         <= 3'b000;
            off_q        <= 2'b00;
            wdata_q      <= 32'h0;
            addr_q       <= '0;
            we_q         <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (is_mis && !TRAP_EN) begin
                            state_q <= SECOND;
                            hold_q  <= mem_data_out;
                            f3_q    <= bus.req_funct3;
                            off_q   <= off;
                            wdata_q <= bus.req_wdata;
                            addr_q  <= bus.req_addr[ADDR_W+1:2];
                            we_q    <= bus.req_we;
                        end else begin
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= (!bus.req_we && is_legal && !is_mis) ? ld_data : 32'h0;
                        end
                    end
                end
                SECOND: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= we_q ? 32'h0 : ld_data;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic resp_mis_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_mis_q <= 1'b0;
        end else begin
            resp_mis_q <= accept && is_mis;
        end
    end
    assign bus.resp_misaligned = resp_mis_q;
`else
    assign bus.resp_misaligned = 1'b0;
`endif

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed bench for lsu_mem_if with a byte-masked memory model and a response scoreboard queue.
// Latency: n/a.
// Backpressure: requests are only driven while req_ready is high.
module tb_lsu_mem_if;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_bus_if bus ();

    logic        mem_en;
    logic [3:0]  mem_mask;
    logic [31:0] mem_data_in;
    logic [11:0] mem_address;
    logic [31:0] mem_data_out;
    logic [31:0] mem [4096];

    lsu_mem_if #(.ADDR_W(12), .XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .mem_en       (mem_en),
        .mem_mask     (mem_mask),
        .mem_data_in  (mem_data_in),
        .mem_address  (mem_address),
        .mem_data_out (mem_data_out)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    assign mem_data_out = mem[mem_address];
    always @(posedge clk) if (mem_en) mem[mem_address] <= merge(mem[mem_address], mem_data_in, mem_mask);

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
    } exp_t;
    exp_t exp_q[$];

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and score any response against the oldest expectation.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (bus.resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", 32'(bus.resp_valid), 32'(exp_q.size()));
            end else begin
                e = exp_q.pop_front();
                check("resp_rdata", bus.resp_rdata, e.rdata);
                check("resp_misaligned", 32'(bus.resp_misaligned), 32'(e.mis));
            end
        end
    endtask

    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] er, input logic em, input bit push);
        exp_t e;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        e.rdata = er;
        e.mis   = em;
        if (push) exp_q.push_back(e);
    endtask

    task automatic idle();
        bus.req_valid = 1'b0;
    endtask

    task automatic req1(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] er);
        send(we, f3, addr, wdata, er, 1'b0, 1'b1);
        tick();
        idle();
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        check("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        send(1'b1, F3_W, 32'h10, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
        #2;
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_mask", 32'(mem_mask), 32'd0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'h0);
        check("rst_resp_mis", 32'(bus.resp_misaligned), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        idle();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Aligned word store.
        send(1'b1, F3_W, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1);
        #1;
        check("sw_en", 32'(mem_en), 32'd1);
        check("sw_addr", 32'(mem_address), 32'd4);
        check("sw_mask", 32'(mem_mask), 32'hF);
        check("sw_data", mem_data_in, 32'hDEAD_BEEF);
        tick();
        idle();
        #1 check("sw_en_after", 32'(mem_en), 32'd0);

        // Loads with extension, issued back to back.
        req1(1'b1, F3_W, 32'h10, 32'h8081_F0FF, 32'h0);
        send(1'b0, F3_B, 32'h12, 32'h0, 32'hFFFF_FF81, 1'b0, 1'b1);
        #1 check("ld_en", 32'(mem_en), 32'd0);
        tick();
        send(1'b0, F3_BU, 32'h12, 32'h0, 32'h0000_0081, 1'b0, 1'b1);
        tick();
        send(1'b0, F3_HU, 32'h12, 32'h0, 32'h0000_8081, 1'b0, 1'b1);
        tick();
        send(1'b0, F3_H, 32'h10, 32'h0, 32'hFFFF_F0FF, 1'b0, 1'b1);
        tick();
        idle();
        drain(4);

        // Upper address bits ignored.
        req1(1'b0, F3_W, 32'h4010, 32'h0, 32'h8081_F0FF);

        // Illegal store funct3: no write, zero response; illegal load likewise.
        send(1'b1, 3'b011, 32'h10, 32'h1234_5678, 32'h0, 1'b0, 1'b1);
        #1 check("illegal_st_en", 32'(mem_en), 32'd0);
        tick();
        idle();
        req1(1'b1, F3_BU, 32'h10, 32'h1234_5678, 32'h0);
        req1(1'b0, 3'b110, 32'h10, 32'h0, 32'h0);
        req1(1'b0, F3_W, 32'h10, 32'h0, 32'h8081_F0FF);

        // Misaligned load LW 0x21 over words 8/9.
        req1(1'b1, F3_W, 32'h20, 32'h0102_0304, 32'h0);
        req1(1'b1, F3_W, 32'h24, 32'h0506_0708, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        send(1'b0, F3_W, 32'h21, 32'h0, 32'h0, 1'b1, 1'b1);
        #1 check("trap_ld_en", 32'(mem_en), 32'd0);
        tick();
        idle();
        send(1'b1, F3_H, 32'h13, 32'h0000_A55A, 32'h0, 1'b1, 1'b1);
        #1 check("trap_st_en", 32'(mem_en), 32'd0);
        tick();
        idle();
        req1(1'b0, F3_W, 32'h10, 32'h0, 32'h8081_F0FF);
`else
        send(1'b0, F3_W, 32'h21, 32'h0, 32'h0801_0203, 1'b0, 1'b1);
        tick();
        idle();
        tick();

        // Misaligned halfword store across words 4/5.
        req1(1'b1, F3_W, 32'h14, 32'h0, 32'h0);
        send(1'b1, F3_H, 32'h13, 32'h0000_A55A, 32'h0, 1'b0, 1'b1);
        #1;
        check("sh_b1_addr", 32'(mem_address), 32'd4);
        check("sh_b1_mask", 32'(mem_mask), 32'h8);
        check("sh_b1_data", mem_data_in, 32'h5A00_0000);
        tick();
        idle();
        #1;
        check("sh_b2_ready", 32'(bus.req_ready), 32'd0);
        check("sh_b2_en", 32'(mem_en), 32'd1);
        check("sh_b2_addr", 32'(mem_address), 32'd5);
        check("sh_b2_mask", 32'(mem_mask), 32'h1);
        check("sh_b2_data", mem_data_in, 32'h0000_00A5);
        check("sh_b2_resp", 32'(bus.resp_valid), 32'd0);
        tick();
        check("sh_done_ready", 32'(bus.req_ready), 32'd1);
        req1(1'b0, F3_W, 32'h10, 32'h0, 32'h5A81_F0FF);
        req1(1'b0, F3_W, 32'h14, 32'h0, 32'h0000_00A5);

        // Misaligned word load wrapping 4095 -> 0.
        req1(1'b1, F3_W, 32'h3FFC, 32'h1122_3344, 32'h0);
        req1(1'b1, F3_W, 32'h0, 32'h5566_7788, 32'h0);
        send(1'b0, F3_W, 32'h3FFE, 32'h0, 32'h7788_1122, 1'b0, 1'b1);
        #1 check("wrap_b1_addr", 32'(mem_address), 32'hFFF);
        tick();
        idle();
        #1 check("wrap_b2_addr", 32'(mem_address), 32'h0);
        tick();

        // Reset during the second beat of a split store.
        req1(1'b1, F3_W, 32'h40, 32'h0, 32'h0);
        req1(1'b1, F3_W, 32'h44, 32'h0, 32'h0);
        send(1'b1, F3_W, 32'h41, 32'hAABB_CCDD, 32'h0, 1'b0, 1'b0);
        #1;
        check("rs_b1_mask", 32'(mem_mask), 32'hE);
        check("rs_b1_data", mem_data_in, 32'hBBCC_DD00);
        tick();
        idle();
        #1 check("rs_second_ready", 32'(bus.req_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("rs_ready", 32'(bus.req_ready), 32'd1);
        check("rs_mem_en", 32'(mem_en), 32'd0);
        check("rs_mem_mask", 32'(mem_mask), 32'd0);
        check("rs_resp_valid", 32'(bus.resp_valid), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        req1(1'b0, F3_W, 32'h40, 32'h0, 32'hBBCC_DD00);
        req1(1'b0, F3_W, 32'h44, 32'h0, 32'h0);
`endif

        drain(10);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu_mem_if.md
Name: lsu_mem_if

Overview:
Load/store unit sitting directly upstream of the word-addressed data memory (4096 x 32, byte-masked synchronous write, combinational read).
- Takes byte-addressed RV32I load/store requests from the execute stage.
- Generates the word address, byte mask and lane-shifted write data for the memory.
- Extracts, sign- or zero-extends and registers load data.
- Splits misaligned accesses into two memory beats.

Parameters:
- ADDR_W, 12, word-address width driven to the memory (4096 words).
- XLEN, 32, data width.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I width/sign code.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- resp_valid  output  1  one-cycle pulse: load data valid, or store complete.
- resp_rdata  output  32  extended load data; 0 for stores.
- resp_misaligned  output  1  misaligned-trap flag (see Optional Feature).
- mem_en  output  1  memory write enable.
- mem_mask  output  4  byte-lane write mask.
- mem_data_in  output  32  lane-shifted store data.
- mem_address  output  ADDR_W  word index.
- mem_data_out  input  32  combinational read data from memory.

Behaviour:
- Reset (async): state=IDLE; resp_valid=0; resp_rdata=0; resp_misaligned=0; hold register=0.
- Reset also forces combinational outputs: mem_en=0, mem_mask=0.
- Word index = req_addr[ADDR_W+1:2]. Upper address bits are ignored, so the address wraps modulo 16 KiB.
- Byte offset off = req_addr[1:0].
- funct3 decode: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads). Stores use 000/001/010.
- Any other funct3, or 1xx on a store, is illegal: no memory write; resp_valid pulses next cycle with rdata=0.
- Handshake: req_ready = (state==IDLE). A request is accepted on req_valid && req_ready.
- State IDLE, aligned access (H with off[0]=0, W with off=0, any B):
  - Store: mem_en=1 in the accept cycle with mask = size mask << off and data = wdata << (8*off). resp_valid next cycle.
  - Load: mem_data_out sampled in the accept cycle, shifted right by 8*off, extended per funct3, registered. resp_valid/resp_rdata appear next cycle.
  - Latency is 1; the unit stays in IDLE, so back-to-back accepts are possible.
- Misaligned access (H with off=3, W with off!=0):
  - The unit moves to SECOND and req_ready drops.
  - Beat 1 (accept cycle) uses word A: store writes the low lanes (mask & 4'hF); load captures mem_data_out in the hold register.
  - The request (funct3, off, wdata, A) is latched.
  - Beat 2 (SECOND state) uses word (A+1) mod 2^ADDR_W. Wrap 4095->0 is required.
  - Store writes the spilled upper lanes of the 8-byte shifted mask and data.
  - Load concatenates {mem_data_out, hold} >> 8*off and extends.
  - Return to IDLE; resp_valid the following cycle. Latency is 2.
- Extension: B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
- Reset in SECOND: return to IDLE immediately, no response. A beat-1 store write is already committed and is not rolled back.
- While resp_valid=1, a new request may be accepted in the same cycle; its response pulses in the following cycle.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: misaligned requests do not access memory (mem_en=0) and never enter SECOND. resp_valid and resp_misaligned pulse together next cycle, with rdata=0.
- Undefined: the split path above is used; resp_misaligned is tied 0.

Decomposition:
- Package lsu_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the state enum IDLE/SECOND;
  - the size-to-mask function.
- One sub-module, lsu_align: a purely combinational 64-bit lane shifter plus sign/zero extender, shared by the load and store paths.

Test Plan:
1. SW addr 0x10, wdata 0xDEADBEEF -> mem_address=4, mask=1111, data=0xDEADBEEF for 1 cycle; resp_valid next cycle.
2. Word 4 = 0x8081F0FF; LB 0x12 -> rdata 0xFFFFFF81; LBU 0x12 -> 0x00000081; LHU 0x12 -> 0x00008081; LH 0x10 -> 0xFFFFF0FF.
3. SH 0x13, wdata 0x0000A55A:
   - beat 1: word 4, mask 1000, data 0x5A000000;
   - beat 2: word 5, mask 0001, data 0x000000A5;
   - req_ready=0 in SECOND; resp after 2 cycles.
4. LW 0x3FFE, word 4095=0x11223344, word 0=0x55667788 -> second beat word 0; rdata 0x77881122.
5. Assert rst while in SECOND of a misaligned SW -> state IDLE, mem_en=0, no resp_valid; beat-1 lanes remain written.
6. With LSU_MISALIGN_TRAP_EN: LW 0x21 -> mem_en=0, resp_misaligned=1 and resp_valid=1 next cycle, rdata=0. Illegal funct3 011 store -> no write, rdata 0.
